// File: rtl/ciphertext_pkg.sv
// Shared constants and state encoding for the ciphertext receive path.
package ciphertext_pkg;

  localparam int unsigned REGISTER_SIZE  = 32;
  localparam int unsigned N_SQUARED_SIZE = 4096;
  localparam int unsigned NUM_CT_BLOCKS  = N_SQUARED_SIZE / REGISTER_SIZE;
  localparam int unsigned FRAME_COUNT_W  = 16;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } collector_state_t;

endpackage

// File: rtl/ciphertext_collector_if.sv
// Word-stream bus between spi_pe, the collector and the Montgomery datapath.
interface ciphertext_collector_if #(
  parameter int unsigned REGISTER_SIZE = ciphertext_pkg::REGISTER_SIZE
);

  logic [REGISTER_SIZE-1:0]                 data_in;
  logic                                     valid_in;
  logic                                     consumed_in;
  logic [REGISTER_SIZE-1:0]                 data_out;
  logic                                     valid_out;
  logic                                     last_out;
  logic [ciphertext_pkg::FRAME_COUNT_W-1:0] frame_count_out;
  logic                                     overflow_out;
  logic                                     timeout_out;

  modport master (
    output data_in, valid_in, consumed_in,
    input  data_out, valid_out, last_out, frame_count_out, overflow_out, timeout_out
  );

  modport slave (
    input  data_in, valid_in, consumed_in,
    output data_out, valid_out, last_out, frame_count_out, overflow_out, timeout_out
  );

endinterface

// File: rtl/evt_counter.sv
// Generic event counter: synchronous clear has priority over increment, wraps naturally.
module evt_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/word_buffer.sv
// Simple dual-port single-clock RAM with a registered read port (1-cycle latency).
module word_buffer #(
  parameter int unsigned DEPTH = ciphertext_pkg::NUM_CT_BLOCKS,
  parameter int unsigned WIDTH = ciphertext_pkg::REGISTER_SIZE,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Storage array is left unreset so it maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ciphertext_collector.sv
// Collects one ciphertext frame of words, then replays it under a consumed-pulse handshake.
// Optional partial-frame idle timeout is built when FRAME_TIMEOUT_EN is defined.
module ciphertext_collector #(
  parameter int unsigned REGISTER_SIZE  = ciphertext_pkg::REGISTER_SIZE,
  parameter int unsigned BITS_IN_NUM    = ciphertext_pkg::N_SQUARED_SIZE,
  parameter int unsigned TIMEOUT_CYCLES = 100_000
) (
  input logic                   clk_in,
  input logic                   rst_in,
  ciphertext_collector_if.slave bus
);

  import ciphertext_pkg::collector_state_t;
  import ciphertext_pkg::FILL;
  import ciphertext_pkg::LOAD;
  import ciphertext_pkg::DRAIN;
  import ciphertext_pkg::FRAME_COUNT_W;

  localparam int unsigned NUM_BLOCKS = BITS_IN_NUM / REGISTER_SIZE;
  localparam int unsigned AW         = $clog2(NUM_BLOCKS);

  if (NUM_BLOCKS < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("ciphertext_collector: need at least 2 blocks and TIMEOUT_CYCLES >= 2");
  end

  collector_state_t         state_q;
  logic                     valid_q;
  logic                     last_q;
  logic                     overflow_q;
  logic [AW-1:0]            wr_idx;
  logic [AW-1:0]            rd_idx;
  logic [FRAME_COUNT_W-1:0] frame_cnt;
  logic [REGISTER_SIZE-1:0] rd_data;

  logic wr_en_c;
  logic wr_last_c;
  logic rd_en_c;
  logic consume_c;
  logic rd_last_c;
  logic frame_done_c;
  logic expire_c;

  assign wr_en_c      = (state_q == FILL) && bus.valid_in;
  assign wr_last_c    = wr_en_c && (wr_idx == AW'(NUM_BLOCKS - 1));
  assign rd_en_c      = (state_q == LOAD);
  assign consume_c    = (state_q == DRAIN) && bus.consumed_in;
  assign rd_last_c    = (rd_idx == AW'(NUM_BLOCKS - 1));
  assign frame_done_c = consume_c && rd_last_c;

  evt_counter #(.WIDTH(AW)) u_wr_idx (
    .clk_i (clk_in),
    .rst_i (rst_in),
    .clr_i (wr_last_c || expire_c),
    .inc_i (wr_en_c),
    .cnt_o (wr_idx)
  );

  evt_counter #(.WIDTH(AW)) u_rd_idx (
    .clk_i (clk_in),
    .rst_i (rst_in),
    .clr_i (frame_done_c),
    .inc_i (consume_c),
    .cnt_o (rd_idx)
  );

  evt_counter #(.WIDTH(FRAME_COUNT_W)) u_frame_cnt (
    .clk_i (clk_in),
    .rst_i (rst_in),
    .clr_i (1'b0),
    .inc_i (frame_done_c),
    .cnt_o (frame_cnt)
  );

  word_buffer #(
    .DEPTH (NUM_BLOCKS),
    .WIDTH (REGISTER_SIZE),
    .AW    (AW)
  ) u_buffer (
    .clk_i   (clk_in),
    .rst_i   (rst_in),
    .we_i    (wr_en_c),
    .waddr_i (wr_idx),
    .wdata_i (bus.data_in),
    .re_i    (rd_en_c),
    .raddr_i (rd_idx),
    .rdata_o (rd_data)
  );

  // Fill / load / drain sequencing; LOAD is the one-cycle read bubble before each word.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= FILL;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if ((state_q != FILL) && bus.valid_in) begin
        overflow_q <= 1'b1;
      end
      unique case (state_q)
        FILL: begin
          if (wr_last_c) begin
            state_q <= LOAD;
          end
        end
        LOAD: begin
          state_q <= DRAIN;
          valid_q <= 1'b1;
          last_q  <= rd_last_c;
        end
        DRAIN: begin
          if (bus.consumed_in) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            state_q <= rd_last_c ? FILL : LOAD;
          end
        end
        default: begin
          state_q <= FILL;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FRAME_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] idle_q;
  logic          timeout_q;
  logic          idle_run_c;

  // Counter holds cycles elapsed since the last stored word; an arriving word always wins.
  assign idle_run_c = (state_q == FILL) && (wr_idx != '0) && !bus.valid_in;
  assign expire_c   = idle_run_c && (idle_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= expire_c;
      if (wr_en_c) begin
        idle_q <= TW'(1);
      end else if (idle_run_c && !expire_c) begin
        idle_q <= idle_q + TW'(1);
      end else begin
        idle_q <= '0;
      end
    end
  end

  assign bus.timeout_out = timeout_q;
`else
  assign expire_c        = 1'b0;
  assign bus.timeout_out = 1'b0;
`endif

  assign bus.data_out        = rd_data;
  assign bus.valid_out       = valid_q;
  assign bus.last_out        = last_q;
  assign bus.frame_count_out = frame_cnt;
  assign bus.overflow_out    = overflow_q;

endmodule

// File: tb/tb_ciphertext_collector.sv
// Scoreboard bench for ciphertext_collector: frame-level reference model feeds an expected-word queue.
module tb_ciphertext_collector;

  localparam int unsigned NB = 128;

  typedef struct {
    logic [31:0] data;
    logic        last;
    int          idx;
  } exp_t;

  logic clk_in = 1'b0;
  logic rst_in;

  ciphertext_collector_if #(.REGISTER_SIZE(32)) bus ();

  ciphertext_collector #(
    .REGISTER_SIZE  (32),
    .BITS_IN_NUM    (4096),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] fill_q [$];
  exp_t        exp_q [$];
  bit          draining   = 0;
  bit          ovf_exp    = 0;
  int          frames_exp = 0;

  // Monitor-visible state
  bit   consume_en = 1;
  int   stop_idx   = -1;
  bit   mon_have   = 0;
  int   mon_idx    = -1;
  exp_t e;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endfunction

  // Frame-level behaviour: words accumulate in arrival order; arrivals during replay are dropped.
  function automatic void model_word(input logic [31:0] w);
    if (draining) begin
      ovf_exp = 1;
    end else begin
      fill_q.push_back(w);
      if (fill_q.size() == NB) begin
        for (int i = 0; i < int'(NB); i++) begin
          exp_q.push_back('{data: fill_q[i], last: (i == int'(NB) - 1), idx: i});
        end
        fill_q.delete();
        draining = 1;
      end
    end
  endfunction

  function automatic void model_reset();
    fill_q.delete();
    exp_q.delete();
    draining   = 0;
    ovf_exp    = 0;
    frames_exp = 0;
  endfunction

  task automatic send_word(input logic [31:0] w);
    @(negedge clk_in);
    bus.valid_in = 1'b1;
    bus.data_in  = w;
    model_word(w);
    @(negedge clk_in);
    bus.valid_in = 1'b0;
  endtask

  task automatic send_frame(input int kind, input int n);
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk_in);
      w = (kind == 0) ? (32'h1000_0000 + 32'(i)) : 32'($urandom);
      send_word(w);
    end
  endtask

  task automatic wait_drained(input string name);
    int n = 0;
    while ((draining || exp_q.size() != 0) && n < 20000) begin
      @(negedge clk_in);
      n++;
    end
    check({name, "_drain_bound"}, 64'(n >= 20000), 64'(0));
    repeat (2) @(negedge clk_in);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_data"},  64'(bus.data_out),        64'(0));
    check({name, "_valid"}, 64'(bus.valid_out),       64'(0));
    check({name, "_last"},  64'(bus.last_out),        64'(0));
    check({name, "_frame"}, 64'(bus.frame_count_out), 64'(0));
    check({name, "_ovf"},   64'(bus.overflow_out),    64'(0));
    check({name, "_tmo"},   64'(bus.timeout_out),     64'(0));
  endtask

  // Monitor / consumer: pops the scoreboard whenever a new word is presented.
  initial begin : monitor
    logic [31:0] held;
    int          wait_cnt;
    bit          exp_next;
    held     = '0;
    wait_cnt = 0;
    exp_next = 0;
    bus.consumed_in = 1'b0;
    forever begin
      @(negedge clk_in);
      if (rst_in) begin
        mon_have = 0;
        exp_next = 0;
        continue;
      end
      if (exp_next) begin
        check("next_word_valid", 64'(bus.valid_out), 64'(1));
        exp_next = 0;
      end
      if (!bus.valid_out) begin
        mon_have = 0;
        continue;
      end
      if (!mon_have) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 64'(bus.data_out), 64'(0));
          e = '{data: 32'h0, last: 1'b0, idx: -2};
        end else begin
          e = exp_q.pop_front();
          check($sformatf("word%0d_data", e.idx), 64'(bus.data_out), 64'(e.data));
          check($sformatf("word%0d_last", e.idx), 64'(bus.last_out), 64'(e.last));
        end
        held     = bus.data_out;
        mon_have = 1;
        mon_idx  = e.idx;
        wait_cnt = int'($urandom_range(0, 4));
      end else begin
        check("data_hold", 64'(bus.data_out), 64'(held));
      end
      if (consume_en && (e.idx != stop_idx) && wait_cnt == 0) begin
        bus.consumed_in = 1'b1;
        @(negedge clk_in);
        bus.consumed_in = 1'b0;
        check("bubble_after_consume", 64'(bus.valid_out), 64'(0));
        mon_have = 0;
        exp_next = !e.last;
        if (e.last) begin
          draining = 0;
          frames_exp++;
        end
      end else if (wait_cnt > 0) begin
        wait_cnt--;
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int first;
    int pulses;
    int n;
    bus.valid_in = 1'b0;
    bus.data_in  = '0;
    rst_in       = 1'b1;
    repeat (3) @(negedge clk_in);
    check_outputs_zero("reset");
    rst_in = 1'b0;

    // Full incrementing frame plus latency of the first word
    send_frame(0, NB);
    check("latency_t1_valid", 64'(bus.valid_out), 64'(0));
    @(negedge clk_in);
    check("latency_t2_valid", 64'(bus.valid_out), 64'(1));
    wait_drained("frameA");
    check("frameA_count", 64'(bus.frame_count_out), 64'(frames_exp));
    check("frameA_count_abs", 64'(bus.frame_count_out), 64'(1));
    check("frameA_ovf", 64'(bus.overflow_out), 64'(0));

    // Random frame with an intrusive word during replay
    send_frame(1, NB);
    n = 0;
    while (!(mon_have && mon_idx >= 20) && n < 5000) begin
      @(negedge clk_in);
      n++;
    end
    check("ovf_wait_bound", 64'(n >= 5000), 64'(0));
    send_word(32'hDEAD_BEEF);
    check("ovf_set", 64'(bus.overflow_out), 64'(ovf_exp));
    wait_drained("frameB");
    check("frameB_count", 64'(bus.frame_count_out), 64'(2));
    check("frameB_ovf_sticky", 64'(bus.overflow_out), 64'(1));

    send_frame(1, NB);
    wait_drained("frameC");
    check("frameC_count", 64'(bus.frame_count_out), 64'(frames_exp));
    check("frameC_ovf_sticky", 64'(bus.overflow_out), 64'(1));

    // Reset while word 64 is presented
    stop_idx = 64;
    send_frame(1, NB);
    n = 0;
    while (!(mon_have && mon_idx == 64) && n < 5000) begin
      @(negedge clk_in);
      n++;
    end
    check("stop64_bound", 64'(n >= 5000), 64'(0));
    rst_in = 1'b1;
    @(negedge clk_in);
    check_outputs_zero("midrst");
    model_reset();
    rst_in   = 1'b0;
    stop_idx = -1;
    send_frame(1, NB);
    wait_drained("frameE");
    check("frameE_count", 64'(bus.frame_count_out), 64'(1));
    check("frameE_ovf", 64'(bus.overflow_out), 64'(0));

    // Partial frame followed by an idle gap
    send_frame(1, 10);
    first  = -1;
    pulses = 0;
    for (int k = 1; k <= 70; k++) begin
      if (k > 1) @(negedge clk_in);
      if (bus.timeout_out === 1'b1) begin
        pulses++;
        if (first < 0) first = k;
      end
    end
`ifdef FRAME_TIMEOUT_EN
    check("timeout_cycle", 64'(first), 64'(50));
    check("timeout_pulses", 64'(pulses), 64'(1));
    fill_q.delete();
`else
    check("timeout_pulses", 64'(pulses), 64'(0));
`endif
    send_frame(1, NB);
    wait_drained("frameF");
    check("frameF_count", 64'(bus.frame_count_out), 64'(frames_exp));
    check("frameF_count_abs", 64'(bus.frame_count_out), 64'(2));
    check("frameF_ovf", 64'(bus.overflow_out), 64'(ovf_exp));
    check("final_queue_empty", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
